// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory pipeline stage.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_stage_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  // Contents of the EXE/MEM pipeline register.
  typedef struct packed {
    logic              valid;
    logic              wreg;
    logic              m2reg;
    logic              wmem;
    logic [REG_W-1:0]  rn;
    logic [WORD_W-1:0] b;
    logic [WORD_W-1:0] alu;
  } exmem_t;

  // A memory op (load or store) whose byte address is not word aligned.
  function automatic logic is_misaligned(input exmem_t m);
    return m.valid && (m.wmem || m.m2reg) && (m.alu[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Bundle of EXE-side inputs, hazard controls and MEM/WB-side outputs of mem_stage.
// Latency: n/a (wiring only).
// Backpressure: stall/flush come from the hazard unit through this bundle.
// Ports: master = upstream/hazard side driving e*, stall, flush;
//        slave  = mem_stage, driving the m*/w* registers and error flag.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic              ewreg;
  logic              em2reg;
  logic              ewmem;
  logic [REG_W-1:0]  ern;
  logic [WORD_W-1:0] eb;
  logic [WORD_W-1:0] ealu;
  logic              stall;
  logic              flush;

  logic              mwreg;
  logic              mm2reg;
  logic              mwmem;
  logic [REG_W-1:0]  mrn;
  logic [WORD_W-1:0] malu;

  logic              wwreg;
  logic              wm2reg;
  logic [REG_W-1:0]  wrn;
  logic [WORD_W-1:0] walu;
  logic [WORD_W-1:0] wdo;

  logic              misalign;
  logic [WORD_W-1:0] bad_addr;

  modport master (
    output ewreg, em2reg, ewmem, ern, eb, ealu, stall, flush,
    input  mwreg, mm2reg, mwmem, mrn, malu,
    input  wwreg, wm2reg, wrn, walu, wdo, misalign, bad_addr
  );

  modport slave (
    input  ewreg, em2reg, ewmem, ern, eb, ealu, stall, flush,
    output mwreg, mm2reg, mwmem, mrn, malu,
    output wwreg, wm2reg, wrn, walu, wdo, misalign, bad_addr
  );

endinterface

// File: rtl/mem_stage_data_ram.sv
// Word-addressed data memory: synchronous write, asynchronous read, no reset.
// Latency: write lands at the clock edge, read is combinational.
// Backpressure: none; the caller gates the write enable.
// Ports: clk, we, addr (word address), wdata, rdata.
module data_ram
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // A same-word read during a write returns the old contents.
  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EXE/MEM register, data memory access, MEM/WB register, misalign trap.
// Latency: 1 cycle EXE->MEM outputs, 1 cycle MEM->WB outputs.
// Backpressure: stall holds EXE/MEM and sends a bubble to WB; flush bubbles EXE/MEM.
// Ports: clk, rst (sync, active-high), bus (mem_stage_if.slave: EXE inputs,
//        stall/flush, forwarding outputs m*, writeback outputs w*, misalign/bad_addr).
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);

  exmem_t            m_q;
  logic              misaligned;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [WORD_W-1:0] rdata;

  logic              wvalid;
  logic              wwreg_q;
  logic              wm2reg_q;
  logic [REG_W-1:0]  wrn_q;
  logic [WORD_W-1:0] walu_q;
  logic [WORD_W-1:0] wdo_q;

  logic              misalign_q;
  logic [WORD_W-1:0] bad_addr_q;

  // EXE/MEM register: rst > flush > stall > load.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      m_q <= '0;
    end else if (!bus.stall) begin
      m_q <= '{valid: 1'b1,
               wreg:  bus.ewreg,
               m2reg: bus.em2reg,
               wmem:  bus.ewmem,
               rn:    bus.ern,
               b:     bus.eb,
               alu:   bus.ealu};
    end
  end

  // Upper address bits are dropped, so addresses wrap modulo DEPTH words.
  assign waddr      = m_q.alu[AW+1:2];
  assign misaligned = is_misaligned(m_q);

  // A stalled store writes once, on the release cycle; flush only affects
  // the instruction entering EXE/MEM, so it does not block this write.
  assign we = m_q.valid && m_q.wmem && !bus.stall && !misaligned && !rst;

  data_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .addr  (waddr),
    .wdata (m_q.b),
    .rdata (rdata)
  );

  // MEM/WB register. A stall inserts a bubble while the data fields hold;
  // a misaligned access is killed by dropping its valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      wvalid   <= 1'b0;
      wwreg_q  <= 1'b0;
      wm2reg_q <= 1'b0;
      wrn_q    <= '0;
      walu_q   <= '0;
      wdo_q    <= '0;
    end else if (bus.stall) begin
      wvalid   <= 1'b0;
      wwreg_q  <= 1'b0;
      wm2reg_q <= 1'b0;
    end else begin
      wvalid   <= m_q.valid && !misaligned;
      wwreg_q  <= m_q.wreg;
      wm2reg_q <= m_q.m2reg;
      wrn_q    <= m_q.rn;
      walu_q   <= m_q.alu;
      wdo_q    <= rdata;
    end
  end

  // Sticky trap: only the first misaligned access records its address.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
      bad_addr_q <= '0;
    end else if (misaligned && !bus.stall && !misalign_q) begin
      misalign_q <= 1'b1;
      bad_addr_q <= m_q.alu;
    end
  end

  assign bus.mwreg    = m_q.wreg;
  assign bus.mm2reg   = m_q.m2reg;
  assign bus.mwmem    = m_q.wmem;
  assign bus.mrn      = m_q.rn;
  assign bus.malu     = m_q.alu;

  assign bus.wwreg    = wvalid && wwreg_q;
  assign bus.wm2reg   = wvalid && wm2reg_q;
  assign bus.wrn      = wrn_q;
  assign bus.walu     = walu_q;
  assign bus.wdo      = wdo_q;

  assign bus.misalign = misalign_q;
  assign bus.bad_addr = bad_addr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus random traffic,
// checked cycle by cycle against a behavioural model through a scoreboard queue.
// Ports: none (top-level bench).
module tb_mem_stage;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  typedef struct packed {
    logic        mwreg;
    logic        mm2reg;
    logic        mwmem;
    logic [4:0]  mrn;
    logic [31:0] malu;
    logic        wwreg;
    logic        wm2reg;
    logic [4:0]  wrn;
    logic [31:0] walu;
    logic [31:0] wdo;
    logic        misalign;
    logic [31:0] bad_addr;
  } snap_t;

  typedef struct {
    bit          valid;
    bit          wreg;
    bit          m2reg;
    bit          wmem;
    int unsigned rn;
    logic [31:0] b;
    logic [31:0] alu;
  } ins_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_stage_if bus ();

  mem_stage #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Scoreboard
  snap_t exp_q[$];
  bit    known_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;

  // Reference model state
  ins_t        r_m;
  bit          r_ww, r_wm;
  logic [4:0]  r_wrn;
  logic [31:0] r_walu, r_wdo;
  bit          r_wdo_known;
  bit          r_mis;
  logic [31:0] r_bad;
  logic [31:0] r_mem   [DEPTH];
  bit          r_known [DEPTH];

  initial begin
    bus.ewreg = 0; bus.em2reg = 0; bus.ewmem = 0; bus.ern = 0;
    bus.eb = 0; bus.ealu = 0; bus.stall = 0; bus.flush = 0;
    for (int i = 0; i < DEPTH; i++) r_known[i] = 0;
  end

  // Present one cycle of inputs, advance the model to the state after the
  // coming clock edge and queue that state as the expected DUT outputs.
  task automatic drive(input bit r, input bit wr, input bit m2, input bit wm,
                       input logic [4:0] rn, input logic [31:0] b,
                       input logic [31:0] alu, input bit st, input bit fl);
    bit          mis_now;
    int unsigned idx;
    logic [31:0] rd;
    bit          rk;
    snap_t       s;
    @(negedge clk);
    rst = r; bus.ewreg = wr; bus.em2reg = m2; bus.ewmem = wm; bus.ern = rn;
    bus.eb = b; bus.ealu = alu; bus.stall = st; bus.flush = fl;

    mis_now = r_m.valid && (r_m.wmem || r_m.m2reg) && (r_m.alu % 4 != 0);
    idx     = (r_m.alu / 4) % DEPTH;
    rd      = r_mem[idx];
    rk      = r_known[idx];
    if (r) begin
      r_m = '{default: 0};
      r_ww = 0; r_wm = 0; r_wrn = 0; r_walu = 0; r_wdo = 0; r_wdo_known = 1;
      r_mis = 0; r_bad = 0;
    end else begin
      if (r_m.valid && r_m.wmem && !st && !mis_now) begin
        r_mem[idx]   = r_m.b;
        r_known[idx] = 1;
      end
      if (st) begin
        r_ww = 0; r_wm = 0;
      end else begin
        r_ww = r_m.valid && r_m.wreg && !mis_now;
        r_wm = r_m.valid && r_m.m2reg && !mis_now;
        r_wrn = 5'(r_m.rn); r_walu = r_m.alu; r_wdo = rd; r_wdo_known = rk;
      end
      if (!r_mis && mis_now && !st) begin
        r_mis = 1; r_bad = r_m.alu;
      end
      if (fl) r_m = '{default: 0};
      else if (!st) r_m = '{1, wr, m2, wm, int'(rn), b, alu};
    end

    s.mwreg = r_m.wreg; s.mm2reg = r_m.m2reg; s.mwmem = r_m.wmem;
    s.mrn = 5'(r_m.rn); s.malu = r_m.alu;
    s.wwreg = r_ww; s.wm2reg = r_wm; s.wrn = r_wrn; s.walu = r_walu;
    s.wdo = r_wdo; s.misalign = r_mis; s.bad_addr = r_bad;
    exp_q.push_back(s);
    known_q.push_back(r_wdo_known);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: checks each expected state just after the edge that produces it.
  initial begin
    snap_t act, exp;
    bit    k;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        k   = known_q.pop_front();
        act = '{bus.mwreg, bus.mm2reg, bus.mwmem, bus.mrn, bus.malu,
                bus.wwreg, bus.wm2reg, bus.wrn, bus.walu, bus.wdo,
                bus.misalign, bus.bad_addr};
        if (!k) begin
          act.wdo = 0;
          exp.wdo = 0;
        end
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL outputs cycle %0d: got m(%b%b%b rn=%0d alu=%h) w(%b%b rn=%0d alu=%h do=%h) err(%b %h) want m(%b%b%b rn=%0d alu=%h) w(%b%b rn=%0d alu=%h do=%h) err(%b %h)",
                   cyc, act.mwreg, act.mm2reg, act.mwmem, act.mrn, act.malu,
                   act.wwreg, act.wm2reg, act.wrn, act.walu, act.wdo,
                   act.misalign, act.bad_addr,
                   exp.mwreg, exp.mm2reg, exp.mwmem, exp.mrn, exp.malu,
                   exp.wwreg, exp.wm2reg, exp.wrn, exp.walu, exp.wdo,
                   exp.misalign, exp.bad_addr);
        end
      end
    end
  end

  initial begin
    logic [31:0] alu;
    int          kind;
    bit          rr, st, fl;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Fill every word so later reads are fully predictable.
    for (int i = 0; i < DEPTH; i++)
      drive(0, 0, 0, 1, 0, 32'hA500_0000 + 32'(i) * 32'h0101, 32'(i * 4), 0, 0);
    idle(2);

    // Store then load.
    drive(0, 0, 0, 1, 0, 32'hDEADBEEF, 32'h10, 0, 0);
    drive(0, 1, 1, 0, 5, 0, 32'h10, 0, 0);
    idle(3);

    // ALU passthrough.
    drive(0, 1, 0, 0, 3, 0, 32'h1234, 0, 0);
    idle(2);

    // Store held by a 3-cycle stall, then load it back.
    drive(0, 0, 0, 1, 0, 32'h55, 32'h8, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 7, 0, 32'h40, 1, 0);
    drive(0, 1, 1, 0, 9, 0, 32'h8, 0, 0);
    idle(3);

    // Flushed store must not reach memory.
    drive(0, 0, 0, 1, 0, 32'h77, 32'h20, 0, 1);
    idle(1);
    drive(0, 1, 1, 0, 4, 0, 32'h20, 0, 0);
    idle(3);

    // Misaligned store, reload word 4, then a second misaligned load.
    drive(0, 0, 0, 1, 0, 32'h99, 32'h13, 0, 0);
    idle(1);
    drive(0, 1, 1, 0, 6, 0, 32'h10, 0, 0);
    idle(1);
    drive(0, 1, 1, 0, 2, 0, 32'h21, 0, 0);
    idle(3);

    // Reset with a load in EXE/MEM, then read earlier data.
    drive(0, 1, 1, 0, 5, 0, 32'h10, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    drive(0, 1, 1, 0, 1, 0, 32'h8, 0, 0);
    idle(3);

    // Random traffic with occasional stall, flush, reset and misalignment.
    for (int n = 0; n < 1500; n++) begin
      rr   = ($urandom_range(0, 59) == 0);
      st   = ($urandom_range(0, 5) == 0);
      fl   = ($urandom_range(0, 9) == 0);
      kind = int'($urandom_range(0, 3));
      alu  = ($urandom_range(0, 255) << 8) | ($urandom_range(0, 63) << 2);
      if ($urandom_range(0, 19) == 0) alu = alu | $urandom_range(1, 3);
      case (kind)
        0: drive(rr, 1, 0, 0, 5'($urandom), $urandom, $urandom, st, fl);
        1: drive(rr, 1, 1, 0, 5'($urandom), $urandom, alu, st, fl);
        2: drive(rr, 0, 0, 1, 5'($urandom), $urandom, alu, st, fl);
        default: drive(rr, 0, 0, 0, 0, 0, 0, st, fl);
      endcase
    end
    idle(2);

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d entries left, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage. It consumes EXE results: write-register enable, mem-to-reg select, memory write enable, destination register, store data and ALU result.
- Contains the EXE/MEM pipeline register, a word-addressed data memory and the MEM/WB pipeline register.
- Feeds the writeback stage. Supports stall and flush from the hazard unit and detects misaligned accesses.

Parameters:
- DEPTH, 64, number of 32-bit words in the data memory (power of two, at least 4).
- AW, 6, word-address width; equals log2(DEPTH).

Ports:
- clk  in  1  stage clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ewreg  in  1  EXE register-write enable.
- em2reg  in  1  EXE mem-to-reg select.
- ewmem  in  1  EXE memory-write enable.
- ern  in  5  EXE destination register (Rd or Rt).
- eb  in  32  EXE store data (qb passthrough).
- ealu  in  32  EXE ALU result; used as byte address for memory ops.
- stall  in  1  hold the EXE/MEM register and insert a bubble into MEM/WB.
- flush  in  1  load a bubble into the EXE/MEM register.
- mwreg, mm2reg, mwmem  out  1 each  EXE/MEM register controls, for forwarding.
- mrn  out  5  EXE/MEM destination register.
- malu  out  32  EXE/MEM ALU result, for forwarding.
- wwreg  out  1  MEM/WB register-write enable.
- wm2reg  out  1  MEM/WB mem-to-reg select.
- wrn  out  5  MEM/WB destination register.
- walu  out  32  MEM/WB ALU result.
- wdo  out  32  MEM/WB loaded data.
- misalign  out  1  sticky error flag.
- bad_addr  out  32  address of the first misaligned access.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. Priority: rst > flush > stall > normal.
- Reset values: all outputs are 0, and the internal valid bits mvalid and wvalid are 0. Reset does not alter data memory contents.
- EXE/MEM register, normal cycle: {mvalid=1, mwreg, mm2reg, mwmem, mrn, mb, malu} <= {1, ewreg, em2reg, ewmem, ern, eb, ealu}.
- EXE/MEM register, flush: mvalid, mwreg, mm2reg and mwmem <= 0. Data fields are don't-care; 0 is preferred.
- EXE/MEM register, stall with no flush: all fields hold.
- Word address: waddr = malu[AW+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Misaligned access: malu[1:0] != 0 while mvalid and (mwmem or mm2reg).
- Memory write: mem[waddr] <= mb at the clock edge when mvalid & mwmem & !stall & !misaligned. During a stall exactly one write occurs, on the release cycle. flush alone does not block the MEM-resident write.
- Memory read: combinational read of mem[waddr], captured into wdo at the edge. Reading and writing the same word in one cycle captures the old data. A store is never also a load, so this case does not arise.
- MEM/WB register, normal cycle: {wvalid, wwreg, wm2reg, wrn, walu, wdo} <= {mvalid, mwreg&mvalid, mm2reg&mvalid, mrn, malu, rdata}.
- MEM/WB register, misaligned access: the instruction is killed. wwreg and wm2reg <= 0 and the write is suppressed.
- MEM/WB register, stall: a bubble is loaded (wvalid, wwreg, wm2reg <= 0).
- Error flag: misalign is set on the first misaligned cycle with !stall and bad_addr <= malu. Both are sticky; only rst clears them, and later errors do not overwrite bad_addr.
- Latency: one cycle EXE to MEM outputs, one cycle MEM to WB outputs.

Decomposition:
- Shared package: constant WORD_W=32 and constant REG_W=5.
- One sub-module, data_ram (DEPTH, AW): synchronous write, asynchronous read, no reset, so it maps to distributed RAM.
- The pipeline registers and error logic stay in mem_stage.

Test Plan:
1. Store then load. Cycle n: ewmem=1, ealu=0x10, eb=0xDEADBEEF. Cycle n+1: em2reg=1, ewreg=1, ern=5, ealu=0x10. Required: two cycles later wdo=0xDEADBEEF, wm2reg=1, wrn=5, wwreg=1.
2. ALU passthrough. ewreg=1, em2reg=0, ern=3, ealu=0x1234. Required: next cycle mwreg=1, malu=0x1234, mrn=3. Cycle after: wwreg=1, walu=0x1234, wm2reg=0. No memory change.
3. Stall on a store. Store 0x55 to 0x8, then hold stall=1 for 3 cycles. Required: mrn and malu hold, wwreg=0 each stalled cycle. Memory at 0x8 is written once, after release. A subsequent load at 0x8 returns 0x55.
4. Flush. Present ewmem=1, ealu=0x20, eb=0x77 together with flush=1. Required: mwmem=0 next cycle, and a later load at 0x20 returns the prior contents, not 0x77.
5. Misalign. Store with ealu=0x13. Required: no write to word 4, misalign=1, bad_addr=0x13, wwreg=0. A second misaligned access at 0x21 leaves bad_addr=0x13.
6. Reset mid-operation. Assert rst while a load is in EXE/MEM. Required: next cycle all outputs=0 and misalign=0, and earlier stored data is still readable after reset.
